// File: rtl/d_reg.sv
// Edge-triggered D register with load enable and complementary outputs.
// Asynchronous active-low clear forces the stored word to RESET_VALUE.
module d_reg #(
    parameter int unsigned WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             MainClock,
    input  logic             ClearB,
    input  logic [WIDTH-1:0] d,
    input  logic             latch,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] state;

    // latch is a synchronous enable; the clock itself is never gated
    always_ff @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            state <= RESET_VALUE;
        end else if (latch) begin
            state <= d;
        end
    end

    assign q   = state;
    assign q_n = ~state;

endmodule

// File: tb/tb_d_reg.sv
// Directed bench for d_reg: vector table on a 4-bit instance plus
// hand sequences for async clear and an 8-bit parameterised instance.
module tb_d_reg;

    logic       clk;
    logic       cb4;
    logic       l4;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [3:0] qn4;

    logic       cb8;
    logic       l8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    int n_run;
    int n_fail;

    d_reg u_dut4 (
        .MainClock(clk),
        .ClearB   (cb4),
        .d        (d4),
        .latch    (l4),
        .q        (q4),
        .q_n      (qn4)
    );

    d_reg #(
        .WIDTH      (8),
        .RESET_VALUE(8'h5A)
    ) u_dut8 (
        .MainClock(clk),
        .ClearB   (cb8),
        .d        (d8),
        .latch    (l8),
        .q        (q8),
        .q_n      (qn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cb;
        logic       ld;
        logic [3:0] d;
        logic [3:0] exp_q;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] exp);
        check({name, ".q"}, {4'h0, q4}, {4'h0, exp});
        check({name, ".q_n"}, {4'h0, qn4}, {4'h0, ~exp});
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 1'b1, 4'hA, 4'h0, "clr0"};
        vecs[1]  = '{1'b0, 1'b1, 4'hA, 4'h0, "clr1"};
        vecs[2]  = '{1'b1, 1'b1, 4'h5, 4'h5, "load5"};
        vecs[3]  = '{1'b1, 1'b0, 4'h3, 4'h5, "hold0"};
        vecs[4]  = '{1'b1, 1'b0, 4'h3, 4'h5, "hold1"};
        vecs[5]  = '{1'b1, 1'b0, 4'h3, 4'h5, "hold2"};
        vecs[6]  = '{1'b1, 1'b1, 4'hF, 4'hF, "loadF"};
        vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'h0, "load0"};
        vecs[8]  = '{1'b1, 1'b0, 4'hC, 4'h0, "hold3"};
        vecs[9]  = '{1'b0, 1'b1, 4'h7, 4'hE, "unused"};
        vecs[10] = '{1'b1, 1'b1, 4'h6, 4'h6, "load6"};
        vecs[11] = '{1'b1, 1'b1, 4'h9, 4'h9, "load9"};
        // entry 9 is clear: expectation fixed below
        vecs[9].exp_q = 4'h0;
        vecs[9].name  = "clr_mid";

        cb4 = 1'b0;
        l4  = 1'b1;
        d4  = 4'hA;
        cb8 = 1'b0;
        l8  = 1'b0;
        d8  = 8'h00;
        #1;
        check4("powerup_clear", 4'h0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cb4 = vecs[i].cb;
            l4  = vecs[i].ld;
            d4  = vecs[i].d;
            @(posedge clk);
            #1;
            check4(vecs[i].name, vecs[i].exp_q);
        end

        // load not visible before the edge
        @(negedge clk);
        l4 = 1'b1;
        d4 = 4'h3;
        #1;
        check4("pre_edge", 4'h9);

        // async clear between edges
        l4 = 1'b0;
        cb4 = 1'b0;
        #1;
        check4("async_clr", 4'h0);
        @(posedge clk);
        #1;
        check4("clr_held", 4'h0);

        @(negedge clk);
        cb4 = 1'b1;
        l4  = 1'b1;
        d4  = 4'hC;
        #1;
        check4("rel_no_edge", 4'h0);
        @(posedge clk);
        #1;
        check4("load_after_rel", 4'hC);

        // clear priority over load
        @(negedge clk);
        cb4 = 1'b0;
        l4  = 1'b1;
        d4  = 4'hF;
        @(posedge clk);
        #1;
        check4("clr_priority", 4'h0);

        // d changes between edges ignored while latch low
        @(negedge clk);
        cb4 = 1'b1;
        l4  = 1'b0;
        d4  = 4'hB;
        @(posedge clk);
        #1;
        d4 = 4'h4;
        @(posedge clk);
        #1;
        check4("d_glitch_hold", 4'h0);

        // 8-bit instance
        check("w8_clr.q", q8, 8'h5A);
        check("w8_clr.q_n", qn8, 8'hA5);
        @(negedge clk);
        cb8 = 1'b1;
        l8  = 1'b1;
        d8  = 8'hFF;
        @(posedge clk);
        #1;
        check("w8_ff.q", q8, 8'hFF);
        check("w8_ff.q_n", qn8, 8'h00);
        @(negedge clk);
        l8 = 1'b0;
        d8 = 8'h12;
        @(posedge clk);
        #1;
        check("w8_hold.q", q8, 8'hFF);
        cb8 = 1'b0;
        #1;
        check("w8_reclr.q", q8, 8'h5A);
        check("w8_reclr.q_n", qn8, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
